// File: rtl/fmps_multiword_read_link.sv
// fmps_multiword_read_link
// FMPS cell-link receiver for header + N-word packets on a beat stream.
// Payload words land in an internal RAM addressed by {fmpsIndex, wordSel};
// a per-frame presence bitmap, success counter and status strobe are kept.
// Optional feature: define PACKET_TIMEOUT_EN to enable an idle watchdog that
// aborts a packet stalled in S_DATA/S_DRAIN after TIMEOUT_CYCLES idle cycles.
module fmps_multiword_read_link #(
  parameter int          INDEX_WIDTH    = 5,
  parameter int          PAYLOAD_WORDS  = 2,
  parameter logic [15:0] HEADER_MAGIC   = 16'hB6CF,
  parameter int          TIMEOUT_CYCLES = 255,
  localparam int         WSW            = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1
) (
  input  logic                         auroraClk,
  input  logic                         auroraResetN,
  input  logic                         FAstrobe,
  input  logic                         allFMPSpresent,
  input  logic                         TVALID,
  input  logic                         TLAST,
  input  logic [31:0]                  TDATA,
  output logic                         statusStrobe,
  output logic [2:0]                   statusCode,
  output logic                         statusFMPSenabled,
  output logic [(1<<INDEX_WIDTH)-1:0]  fmpsBitmap,
  output logic [INDEX_WIDTH:0]         fmpsCounter,
  input  logic [INDEX_WIDTH+WSW-1:0]   readoutAddress,
  output logic [31:0]                  readoutFMPS
);

  localparam int                 SOURCES      = 1 << INDEX_WIDTH;
  localparam int                 RAM_DEPTH    = 1 << (INDEX_WIDTH + WSW);
  localparam logic [WSW-1:0]     LAST_WORD    = WSW'(PAYLOAD_WORDS - 1);
  localparam logic [INDEX_WIDTH:0] COUNTER_MAX = (INDEX_WIDTH + 1)'(SOURCES);
  localparam logic [15:0]        TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  localparam logic [2:0] CODE_OK         = 3'd0;
  localparam logic [2:0] CODE_BAD_HEADER = 3'd1;
  localparam logic [2:0] CODE_BAD_SIZE   = 3'd2;
  localparam logic [2:0] CODE_BAD_PACKET = 3'd3;
`ifdef PACKET_TIMEOUT_EN
  localparam logic [2:0] CODE_TIMEOUT    = 3'd4;
`endif

  typedef enum logic [1:0] {
    S_HEADER = 2'd0,
    S_DATA   = 2'd1,
    S_DRAIN  = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [WSW-1:0]           wordCount_q, wordCount_d;
  logic [INDEX_WIDTH-1:0]   index_q, index_d;
  logic                     word0Invalid_q, word0Invalid_d;
  logic                     enabled_q, enabled_d;
  logic [2:0]               statusCode_q, statusCode_d;
  logic                     statusStrobe_q, statusStrobe_d;
  logic [SOURCES-1:0]       bitmap_q, bitmap_d;
  logic [INDEX_WIDTH:0]     counter_q, counter_d;
  logic [31:0]              readData_q;

  logic                     ramWe;
  logic [INDEX_WIDTH+WSW-1:0] ramAddr;
  logic [31:0]              ramData;
  logic [31:0]              ram [RAM_DEPTH];

  // word0 invalid flag as seen on the deciding beat (word0 may be the last word)
  logic                     word0Bit;
  assign word0Bit = (wordCount_q == '0) ? TDATA[31] : word0Invalid_q;

`ifdef PACKET_TIMEOUT_EN
  logic [15:0] idle_q, idle_d;
  logic [16:0] idleNext;
  assign idleNext = {1'b0, idle_q} + 17'd1;
`else
  logic unusedTimeout;
  assign unusedTimeout = ^TIMEOUT_LIMIT;
`endif

  // Registered control state, status and per-frame bookkeeping
  always_ff @(posedge auroraClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      state_q        <= S_HEADER;
      wordCount_q    <= '0;
      index_q        <= '0;
      word0Invalid_q <= 1'b0;
      enabled_q      <= 1'b0;
      statusCode_q   <= CODE_OK;
      statusStrobe_q <= 1'b0;
      bitmap_q       <= '0;
      counter_q      <= '0;
`ifdef PACKET_TIMEOUT_EN
      idle_q         <= '0;
`endif
    end else begin
      state_q        <= state_d;
      wordCount_q    <= wordCount_d;
      index_q        <= index_d;
      word0Invalid_q <= word0Invalid_d;
      enabled_q      <= enabled_d;
      statusCode_q   <= statusCode_d;
      statusStrobe_q <= statusStrobe_d;
      bitmap_q       <= bitmap_d;
      counter_q      <= counter_d;
`ifdef PACKET_TIMEOUT_EN
      idle_q         <= idle_d;
`endif
    end
  end

  // Packet parser: frame start first, then size checks, then per-state action
  always_comb begin
    state_d        = state_q;
    wordCount_d    = wordCount_q;
    index_d        = index_q;
    word0Invalid_d = word0Invalid_q;
    enabled_d      = enabled_q;
    statusCode_d   = statusCode_q;
    statusStrobe_d = 1'b0;
    bitmap_d       = bitmap_q;
    counter_d      = counter_q;
    ramWe          = 1'b0;
    ramAddr        = {index_q, wordCount_q};
    ramData        = TDATA;
`ifdef PACKET_TIMEOUT_EN
    idle_d         = '0;
`endif

    if (FAstrobe) begin
      bitmap_d    = '0;
      counter_d   = '0;
      state_d     = S_HEADER;
      wordCount_d = '0;
    end else begin
`ifdef PACKET_TIMEOUT_EN
      if ((state_q != S_HEADER) && !TVALID) begin
        if (idleNext >= {1'b0, TIMEOUT_LIMIT}) begin
          statusCode_d   = CODE_TIMEOUT;
          statusStrobe_d = 1'b1;
          state_d        = S_HEADER;
          wordCount_d    = '0;
        end else begin
          idle_d = idleNext[15:0];
        end
      end
`endif
      if (TVALID) begin
        case (state_q)
          S_HEADER: begin
            if (TLAST) begin
              statusCode_d   = CODE_BAD_SIZE;
              statusStrobe_d = 1'b1;
            end else if (TDATA[31:16] == HEADER_MAGIC) begin
              index_d     = TDATA[10 +: INDEX_WIDTH];
              enabled_d   = TDATA[15];
              wordCount_d = '0;
              state_d     = S_DATA;
            end else begin
              statusCode_d   = CODE_BAD_HEADER;
              statusStrobe_d = 1'b1;
              state_d        = S_DRAIN;
            end
          end
          S_DATA: begin
            ramWe = !allFMPSpresent;
            if (wordCount_q == '0) begin
              word0Invalid_d = TDATA[31];
            end
            if (wordCount_q != LAST_WORD) begin
              if (TLAST) begin
                statusCode_d   = CODE_BAD_SIZE;
                statusStrobe_d = 1'b1;
                state_d        = S_HEADER;
                wordCount_d    = '0;
              end else begin
                wordCount_d = wordCount_q + WSW'(1);
              end
            end else if (!TLAST) begin
              statusCode_d   = CODE_BAD_SIZE;
              statusStrobe_d = 1'b1;
              state_d        = S_DRAIN;
              wordCount_d    = '0;
            end else if (TDATA[30]) begin
              statusCode_d   = CODE_BAD_PACKET;
              statusStrobe_d = 1'b1;
              state_d        = S_HEADER;
              wordCount_d    = '0;
            end else begin
              statusCode_d   = CODE_OK;
              statusStrobe_d = 1'b1;
              state_d        = S_HEADER;
              wordCount_d    = '0;
              if (counter_q != COUNTER_MAX) begin
                counter_d = counter_q + (INDEX_WIDTH + 1)'(1);
              end
              if (!allFMPSpresent && !word0Bit) begin
                bitmap_d[index_q] = 1'b1;
              end
            end
          end
          S_DRAIN: begin
            if (TLAST) begin
              state_d = S_HEADER;
            end
          end
          default: begin
            state_d     = S_HEADER;
            wordCount_d = '0;
          end
        endcase
      end
    end
  end

  // Payload RAM write port; contents are not reset
  always_ff @(posedge auroraClk) begin
    if (ramWe) begin
      ram[ramAddr] <= ramData;
    end
  end

  // Registered readout port, returns old data on a same-cycle write
  always_ff @(posedge auroraClk or negedge auroraResetN) begin
    if (!auroraResetN) begin
      readData_q <= '0;
    end else begin
      readData_q <= ram[readoutAddress];
    end
  end

  assign statusStrobe      = statusStrobe_q;
  assign statusCode        = statusCode_q;
  assign statusFMPSenabled = enabled_q;
  assign fmpsBitmap        = bitmap_q;
  assign fmpsCounter       = counter_q;
  assign readoutFMPS       = readData_q;

endmodule
